dcache_cmo_ctrl: RTL and testbench
==================================

Name: dcache_cmo_ctrl

Overview:
- Downstream consumer of CMO requests issued toward the L1 data cache.
- Accepts one cmo_req_t at a time, locks the D$ against the miss/store paths, and looks up the target line.
- Performs clean/flush/inval/zero on the matching way, then returns a single-cycle ack carrying the request trans_id.
- Sits inside the D$ subsystem, between the CMO request port and the tag array / line-operation engine.

Parameters:
NR_WAYS, 4, number of D$ ways
SET_IDX_W, 8, set index width
LINE_OFFSET_W, 4, byte-offset-in-line width
TAG_W, 44, tag width (PLEN 56 - SET_IDX_W - LINE_OFFSET_W)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
cmo_req_i  in  cmo_req_t  req, trans_id, address, cmo_op
cmo_resp_o  out  cmo_resp_t  req_ready, ack, trans_id
lock_req_o  out  1  exclusive D$ access request
lock_gnt_i  in  1  exclusive access granted
tag_req_o  out  1  tag array access
tag_gnt_i  in  1  tag access granted; read data valid the next cycle
tag_we_o  out  1  tag write (else read)
tag_idx_o  out  SET_IDX_W  set index
tag_wway_o  out  NR_WAYS  one-hot write way
tag_wvalid_o  out  1  valid bit written
tag_wdirty_o  out  1  dirty bit written
tag_rtag_i  in  NR_WAYS*TAG_W  per-way tags
tag_rvalid_i  in  NR_WAYS  per-way valid
tag_rdirty_i  in  NR_WAYS  per-way dirty
line_req_o  out  1  line operation request
line_op_o  out  cmo_line_op_t  LINE_WB, LINE_ZERO_LOCAL, LINE_ZERO_MEM
line_idx_o  out  SET_IDX_W  set
line_way_o  out  NR_WAYS  one-hot way
line_tag_o  out  TAG_W  tag, used for writeback and ZERO_MEM addressing
line_gnt_i  in  1  line operation accepted
line_done_i  in  1  line operation complete (pulse)

Behaviour:
Reset:
- Synchronous reset applies at the next clock edge.
- All outputs are 0 after reset, including req_ready.
- Reset mid-operation abandons the operation and drops the lock; the D$ is reset on the same reset.

Request acceptance:
- req_ready = 1 only in IDLE.
- A request is accepted when req & req_ready; trans_id, idx = address[LINE_OFFSET_W +: SET_IDX_W], tag = address[LINE_OFFSET_W+SET_IDX_W +: TAG_W] and op are latched.
- Address bits above PLEN are ignored.

FSM states: IDLE, LOCK, TAG_RD, TAG_CMP, LINE_REQ, LINE_WAIT, TAG_WR, ACK.
- IDLE -> ACK: for CMO_PREFETCH_R/W, CMO_PREFETCH_I and CMO_NONE (no-op hints; ack at accept+1).
- IDLE -> LOCK: for all other ops.
- LOCK: lock_req_o held; on lock_gnt_i -> TAG_RD.
- lock_req_o remains high from LOCK until the ACK cycle inclusive.
- TAG_RD: tag_req_o=1, tag_we_o=0, held until tag_gnt_i -> TAG_CMP.
- TAG_CMP: hit_way = valid & tag match; on multiple matches the lowest index wins. Dispatch:
  - CLEAN: hit & dirty -> LINE_REQ(WB), then TAG_WR(valid=1, dirty=0); hit & clean -> ACK; miss -> ACK.
  - FLUSH: hit & dirty -> LINE_REQ(WB), then TAG_WR(valid=0); hit & clean -> TAG_WR(valid=0); miss -> ACK.
  - INVAL: hit -> TAG_WR(valid=0, dirty data discarded); miss -> ACK.
  - ZERO: hit -> LINE_REQ(ZERO_LOCAL), then TAG_WR(valid=1, dirty=1); miss -> LINE_REQ(ZERO_MEM), then ACK (no allocation).
- LINE_REQ: line_req_o held with stable idx/way/tag/op until line_gnt_i -> LINE_WAIT.
- LINE_WAIT: wait for line_done_i. A line_done_i arriving in the same cycle as line_gnt_i is not possible and is ignored.
- TAG_WR: tag_req_o=1, tag_we_o=1 until tag_gnt_i -> ACK.
- ACK: ack=1 and trans_id driven for exactly one cycle -> IDLE.
- Minimum latency with all grants immediate: miss = ack at accept+4; hit-clean INVAL = accept+5.
- No second request is accepted before the ack cycle has completed.

Decomposition:
- cmo_line_op_t (2-bit enum) goes in ariane_pkg next to cmo_req_t / cmo_resp_t.
- Way selection uses the common_cells lzc on the hit vector; no new sub-module.

Test Plan:
- Reset -> all outputs 0. After release, req_ready=1.
- CMO_INVAL to 0x8000_1230, tag miss, immediate grants -> no tag write, no line op; ack at accept+4 with trans_id=5.
- CMO_FLUSH, hit way 2 dirty -> line_req with op=WB, way=4'b0100, idx=0x23; after line_done, tag write valid=0 on way 2; ack.
- CMO_CLEAN, hit way 0 clean, ways 0 and 3 both matching -> way 0 selected; no line op; ack at accept+4.
- CMO_ZERO miss -> ZERO_MEM with tag=addr[55:12]; no tag write. CMO_ZERO hit way 1 -> ZERO_LOCAL, then tag write dirty=1.
- lock_gnt_i delayed 10 cycles, with a second req held high -> req_ready stays 0 until ack. Reset asserted in LINE_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dcache_cmo_ctrl_pkg.sv
// Shared types and constants for the D$ cache-maintenance-operation controller.
package dcache_cmo_ctrl_pkg;

  localparam int unsigned DC_NR_WAYS       = 4;
  localparam int unsigned DC_SET_IDX_W     = 8;
  localparam int unsigned DC_LINE_OFFSET_W = 4;
  localparam int unsigned DC_PLEN          = 56;
  localparam int unsigned DC_TAG_W         = DC_PLEN - DC_SET_IDX_W - DC_LINE_OFFSET_W;
  localparam int unsigned DC_ADDR_W        = 64;
  localparam int unsigned DC_TRANS_ID_W    = 4;

  typedef enum logic [2:0] {
    CMO_NONE       = 3'd0,
    CMO_CLEAN      = 3'd1,
    CMO_FLUSH      = 3'd2,
    CMO_INVAL      = 3'd3,
    CMO_ZERO       = 3'd4,
    CMO_PREFETCH_I = 3'd5,
    CMO_PREFETCH_R = 3'd6,
    CMO_PREFETCH_W = 3'd7
  } cmo_op_t;

  typedef struct packed {
    logic                     req;
    logic [DC_TRANS_ID_W-1:0] trans_id;
    logic [DC_ADDR_W-1:0]     address;
    cmo_op_t                  cmo_op;
  } cmo_req_t;

  typedef struct packed {
    logic                     req_ready;
    logic                     ack;
    logic [DC_TRANS_ID_W-1:0] trans_id;
  } cmo_resp_t;

  typedef enum logic [1:0] {
    LINE_WB         = 2'd0,
    LINE_ZERO_LOCAL = 2'd1,
    LINE_ZERO_MEM   = 2'd2
  } cmo_line_op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOCK      = 3'd1,
    ST_TAG_RD    = 3'd2,
    ST_TAG_CMP   = 3'd3,
    ST_LINE_REQ  = 3'd4,
    ST_LINE_WAIT = 3'd5,
    ST_TAG_WR    = 3'd6,
    ST_ACK       = 3'd7
  } cmo_state_t;

  // Hint operations never touch the cache; they are acknowledged straight away.
  function automatic logic is_hint(input cmo_op_t op);
    logic res;
    case (op)
      CMO_NONE, CMO_PREFETCH_I, CMO_PREFETCH_R, CMO_PREFETCH_W: res = 1'b1;
      default:                                                   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dcache_cmo_ctrl.sv
// D$ CMO controller: takes one CMO at a time, locks the cache, looks up the
// line and runs clean/flush/inval/zero on the hit way, then acks the request.
// All outputs are registered from the next-state decode so reset forces them 0.
module dcache_cmo_ctrl
  import dcache_cmo_ctrl_pkg::*;
#(
  parameter int unsigned NR_WAYS       = DC_NR_WAYS,
  parameter int unsigned SET_IDX_W     = DC_SET_IDX_W,
  parameter int unsigned LINE_OFFSET_W = DC_LINE_OFFSET_W,
  parameter int unsigned TAG_W         = DC_TAG_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  cmo_req_t                 cmo_req_i,
  output cmo_resp_t                cmo_resp_o,
  output logic                     lock_req_o,
  input  logic                     lock_gnt_i,
  output logic                     tag_req_o,
  input  logic                     tag_gnt_i,
  output logic                     tag_we_o,
  output logic [SET_IDX_W-1:0]     tag_idx_o,
  output logic [NR_WAYS-1:0]       tag_wway_o,
  output logic                     tag_wvalid_o,
  output logic                     tag_wdirty_o,
  input  logic [NR_WAYS*TAG_W-1:0] tag_rtag_i,
  input  logic [NR_WAYS-1:0]       tag_rvalid_i,
  input  logic [NR_WAYS-1:0]       tag_rdirty_i,
  output logic                     line_req_o,
  output cmo_line_op_t             line_op_o,
  output logic [SET_IDX_W-1:0]     line_idx_o,
  output logic [NR_WAYS-1:0]       line_way_o,
  output logic [TAG_W-1:0]         line_tag_o,
  input  logic                     line_gnt_i,
  input  logic                     line_done_i
);

  localparam int unsigned TAG_LSB = LINE_OFFSET_W + SET_IDX_W;

  // Controller state and the latched request context.
  cmo_state_t               state_r, state_s;
  logic [DC_TRANS_ID_W-1:0] trans_id_r, trans_id_s;
  logic [SET_IDX_W-1:0]     idx_r, idx_s;
  logic [TAG_W-1:0]         tag_r, tag_s;
  cmo_op_t                  op_r, op_s;
  logic [NR_WAYS-1:0]       way_r, way_s;
  cmo_line_op_t             lop_r, lop_s;
  logic                     wr_valid_r, wr_valid_s;
  logic                     wr_dirty_r, wr_dirty_s;
  logic                     wr_after_line_r, wr_after_line_s;

  // Lookup results.
  logic [NR_WAYS-1:0]       hit_vec_s;
  logic [NR_WAYS-1:0]       hit_way_s;
  logic                     hit_s;
  logic                     hit_dirty_s;

  // Registered outputs and their next values.
  cmo_resp_t                out_resp_r, out_resp_s;
  logic                     out_lock_req_r, out_lock_req_s;
  logic                     out_tag_req_r, out_tag_req_s;
  logic                     out_tag_we_r, out_tag_we_s;
  logic [SET_IDX_W-1:0]     out_tag_idx_r, out_tag_idx_s;
  logic [NR_WAYS-1:0]       out_tag_wway_r, out_tag_wway_s;
  logic                     out_tag_wvalid_r, out_tag_wvalid_s;
  logic                     out_tag_wdirty_r, out_tag_wdirty_s;
  logic                     out_line_req_r, out_line_req_s;
  cmo_line_op_t             out_line_op_r, out_line_op_s;
  logic [SET_IDX_W-1:0]     out_line_idx_r, out_line_idx_s;
  logic [NR_WAYS-1:0]       out_line_way_r, out_line_way_s;
  logic [TAG_W-1:0]         out_line_tag_r, out_line_tag_s;

  // Address bits outside the set/tag fields carry no meaning for a line CMO.
  logic unused_addr_s;
  assign unused_addr_s = ^{cmo_req_i.address[DC_ADDR_W-1:TAG_LSB+TAG_W],
                           cmo_req_i.address[LINE_OFFSET_W-1:0]};

  // Per-way match: a way hits only when it is valid and its tag equals the latched tag.
  always_comb begin
    hit_vec_s = '0;
    for (int unsigned w = 0; w < NR_WAYS; w++) begin
      hit_vec_s[w] = tag_rvalid_i[w] && (tag_rtag_i[w*TAG_W +: TAG_W] == tag_r);
    end
  end

  // Lowest-index hit wins; x & -x isolates the least significant set bit.
  always_comb begin
    hit_way_s   = hit_vec_s & (~hit_vec_s + NR_WAYS'(1));
    hit_s       = |hit_vec_s;
    hit_dirty_s = |(hit_way_s & tag_rdirty_i);
  end

  // Next-state logic and request-context updates.
  always_comb begin
    state_s         = state_r;
    trans_id_s      = trans_id_r;
    idx_s           = idx_r;
    tag_s           = tag_r;
    op_s            = op_r;
    way_s           = way_r;
    lop_s           = lop_r;
    wr_valid_s      = wr_valid_r;
    wr_dirty_s      = wr_dirty_r;
    wr_after_line_s = wr_after_line_r;
    case (state_r)
      ST_IDLE: begin
        if (cmo_req_i.req && out_resp_r.req_ready) begin
          trans_id_s = cmo_req_i.trans_id;
          idx_s      = cmo_req_i.address[LINE_OFFSET_W +: SET_IDX_W];
          tag_s      = cmo_req_i.address[TAG_LSB +: TAG_W];
          op_s       = cmo_req_i.cmo_op;
          way_s      = '0;
          if (is_hint(cmo_req_i.cmo_op)) begin
            state_s = ST_ACK;
          end else begin
            state_s = ST_LOCK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOCK:   state_s = lock_gnt_i ? ST_TAG_RD : ST_LOCK;
      ST_TAG_RD: state_s = tag_gnt_i ? ST_TAG_CMP : ST_TAG_RD;
      ST_TAG_CMP: begin
        way_s = hit_way_s;
        case (op_r)
          CMO_CLEAN: begin
            if (hit_s && hit_dirty_s) begin
              lop_s = LINE_WB; wr_after_line_s = 1'b1;
              wr_valid_s = 1'b1; wr_dirty_s = 1'b0;
              state_s = ST_LINE_REQ;
            end else begin
              state_s = ST_ACK;
            end
          end
          CMO_FLUSH: begin
            wr_valid_s = 1'b0; wr_dirty_s = 1'b0;
            if (hit_s && hit_dirty_s) begin
              lop_s = LINE_WB; wr_after_line_s = 1'b1;
              state_s = ST_LINE_REQ;
            end else if (hit_s) begin
              state_s = ST_TAG_WR;
            end else begin
              state_s = ST_ACK;
            end
          end
          CMO_INVAL: begin
            wr_valid_s = 1'b0; wr_dirty_s = 1'b0;
            state_s = hit_s ? ST_TAG_WR : ST_ACK;
          end
          CMO_ZERO: begin
            if (hit_s) begin
              lop_s = LINE_ZERO_LOCAL; wr_after_line_s = 1'b1;
              wr_valid_s = 1'b1; wr_dirty_s = 1'b1;
            end else begin
              lop_s = LINE_ZERO_MEM; wr_after_line_s = 1'b0;
            end
            state_s = ST_LINE_REQ;
          end
          default: state_s = ST_ACK;
        endcase
      end
      ST_LINE_REQ: state_s = line_gnt_i ? ST_LINE_WAIT : ST_LINE_REQ;
      ST_LINE_WAIT: begin
        if (line_done_i) begin
          state_s = wr_after_line_r ? ST_TAG_WR : ST_ACK;
        end else begin
          state_s = ST_LINE_WAIT;
        end
      end
      ST_TAG_WR: state_s = tag_gnt_i ? ST_ACK : ST_TAG_WR;
      ST_ACK:    state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so each output is a flop.
  always_comb begin
    out_resp_s.req_ready = (state_s == ST_IDLE);
    out_resp_s.ack       = (state_s == ST_ACK);
    out_resp_s.trans_id  = (state_s == ST_ACK) ? trans_id_s : '0;
    out_lock_req_s       = (state_s inside {ST_LOCK, ST_TAG_RD, ST_TAG_CMP, ST_LINE_REQ,
                                            ST_LINE_WAIT, ST_TAG_WR}) ||
                           ((state_s == ST_ACK) && !is_hint(op_s));
    out_tag_req_s        = (state_s == ST_TAG_RD) || (state_s == ST_TAG_WR);
    out_tag_we_s         = (state_s == ST_TAG_WR);
    out_tag_idx_s        = out_tag_req_s ? idx_s : '0;
    out_tag_wway_s       = out_tag_we_s ? way_s : '0;
    out_tag_wvalid_s     = out_tag_we_s && wr_valid_s;
    out_tag_wdirty_s     = out_tag_we_s && wr_dirty_s;
    out_line_req_s       = (state_s == ST_LINE_REQ);
    out_line_op_s        = out_line_req_s ? lop_s : LINE_WB;
    out_line_idx_s       = out_line_req_s ? idx_s : '0;
    out_line_way_s       = out_line_req_s ? way_s : '0;
    out_line_tag_s       = out_line_req_s ? tag_s : '0;
  end

  // State, context and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r          <= ST_IDLE;
      trans_id_r       <= '0;
      idx_r            <= '0;
      tag_r            <= '0;
      op_r             <= CMO_NONE;
      way_r            <= '0;
      lop_r            <= LINE_WB;
      wr_valid_r       <= 1'b0;
      wr_dirty_r       <= 1'b0;
      wr_after_line_r  <= 1'b0;
      out_resp_r       <= '0;
      out_lock_req_r   <= 1'b0;
      out_tag_req_r    <= 1'b0;
      out_tag_we_r     <= 1'b0;
      out_tag_idx_r    <= '0;
      out_tag_wway_r   <= '0;
      out_tag_wvalid_r <= 1'b0;
      out_tag_wdirty_r <= 1'b0;
      out_line_req_r   <= 1'b0;
      out_line_op_r    <= LINE_WB;
      out_line_idx_r   <= '0;
      out_line_way_r   <= '0;
      out_line_tag_r   <= '0;
    end else begin
      state_r          <= state_s;
      trans_id_r       <= trans_id_s;
      idx_r            <= idx_s;
      tag_r            <= tag_s;
      op_r             <= op_s;
      way_r            <= way_s;
      lop_r            <= lop_s;
      wr_valid_r       <= wr_valid_s;
      wr_dirty_r       <= wr_dirty_s;
      wr_after_line_r  <= wr_after_line_s;
      out_resp_r       <= out_resp_s;
      out_lock_req_r   <= out_lock_req_s;
      out_tag_req_r    <= out_tag_req_s;
      out_tag_we_r     <= out_tag_we_s;
      out_tag_idx_r    <= out_tag_idx_s;
      out_tag_wway_r   <= out_tag_wway_s;
      out_tag_wvalid_r <= out_tag_wvalid_s;
      out_tag_wdirty_r <= out_tag_wdirty_s;
      out_line_req_r   <= out_line_req_s;
      out_line_op_r    <= out_line_op_s;
      out_line_idx_r   <= out_line_idx_s;
      out_line_way_r   <= out_line_way_s;
      out_line_tag_r   <= out_line_tag_s;
    end
  end

  assign cmo_resp_o   = out_resp_r;
  assign lock_req_o   = out_lock_req_r;
  assign tag_req_o    = out_tag_req_r;
  assign tag_we_o     = out_tag_we_r;
  assign tag_idx_o    = out_tag_idx_r;
  assign tag_wway_o   = out_tag_wway_r;
  assign tag_wvalid_o = out_tag_wvalid_r;
  assign tag_wdirty_o = out_tag_wdirty_r;
  assign line_req_o   = out_line_req_r;
  assign line_op_o    = out_line_op_r;
  assign line_idx_o   = out_line_idx_r;
  assign line_way_o   = out_line_way_r;
  assign line_tag_o   = out_line_tag_r;

endmodule

// File: tb/tb_dcache_cmo_ctrl.sv
// Self-checking bench for dcache_cmo_ctrl: vector table plus scoreboard queue,
// with hand sequences for lock back-pressure and reset in LINE_WAIT.
module tb_dcache_cmo_ctrl;
  import dcache_cmo_ctrl_pkg::*;

  localparam int NW = DC_NR_WAYS;
  localparam int SW = DC_SET_IDX_W;
  localparam int OW = DC_LINE_OFFSET_W;
  localparam int TW = DC_TAG_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_ni = 1'b0;
  cmo_req_t             cmo_req_i = '0;
  cmo_resp_t            cmo_resp_o;
  logic                 lock_req_o, lock_gnt_i = 1'b0;
  logic                 tag_req_o, tag_gnt_i = 1'b0, tag_we_o;
  logic [SW-1:0]        tag_idx_o;
  logic [NW-1:0]        tag_wway_o;
  logic                 tag_wvalid_o, tag_wdirty_o;
  logic [NW*TW-1:0]     tag_rtag_i = '0;
  logic [NW-1:0]        tag_rvalid_i = '0, tag_rdirty_i = '0;
  logic                 line_req_o;
  cmo_line_op_t         line_op_o;
  logic [SW-1:0]        line_idx_o;
  logic [NW-1:0]        line_way_o;
  logic [TW-1:0]        line_tag_o;
  logic                 line_gnt_i = 1'b0, line_done_i = 1'b0;

  dcache_cmo_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .cmo_req_i(cmo_req_i), .cmo_resp_o(cmo_resp_o),
    .lock_req_o(lock_req_o), .lock_gnt_i(lock_gnt_i),
    .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i), .tag_we_o(tag_we_o),
    .tag_idx_o(tag_idx_o), .tag_wway_o(tag_wway_o), .tag_wvalid_o(tag_wvalid_o),
    .tag_wdirty_o(tag_wdirty_o), .tag_rtag_i(tag_rtag_i), .tag_rvalid_i(tag_rvalid_i),
    .tag_rdirty_i(tag_rdirty_i), .line_req_o(line_req_o), .line_op_o(line_op_o),
    .line_idx_o(line_idx_o), .line_way_o(line_way_o), .line_tag_o(line_tag_o),
    .line_gnt_i(line_gnt_i), .line_done_i(line_done_i)
  );

  typedef struct {
    cmo_op_t      op;
    logic [63:0]  addr;
    logic [3:0]   tid;
    logic [3:0]   hitm, vld, dty;
    int           ldly;
    int           lat;
    logic         lock;
    logic         line;
    cmo_line_op_t lop;
    logic [3:0]   lway;
    logic         wr, wv, wd;
    logic [3:0]   wway;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] tagof(input logic [63:0] a);
    return a[OW+SW +: TW];
  endfunction

  function automatic logic [SW-1:0] idxof(input logic [63:0] a);
    return a[OW +: SW];
  endfunction

  function automatic vec_t mk(input cmo_op_t op, input logic [63:0] addr, input logic [3:0] tid,
                              input logic [3:0] hitm, input logic [3:0] vld, input logic [3:0] dty,
                              input int ldly, input int lat, input logic lock, input logic line,
                              input cmo_line_op_t lop, input logic [3:0] lway, input logic wr,
                              input logic wv, input logic wd, input logic [3:0] wway);
    vec_t v;
    v.op = op; v.addr = addr; v.tid = tid; v.hitm = hitm; v.vld = vld; v.dty = dty;
    v.ldly = ldly; v.lat = lat; v.lock = lock; v.line = line; v.lop = lop; v.lway = lway;
    v.wr = wr; v.wv = wv; v.wd = wd; v.wway = wway;
    return v;
  endfunction

  // Environment responder: immediate tag/line grants, lock grant after lock_delay cycles,
  // line_done one cycle after the line grant.
  int   lock_delay = 0;
  int   lock_cnt   = 0;
  logic line_pend  = 1'b0;
  always @(negedge clk) begin
    if (!rst_ni) begin
      lock_gnt_i = 1'b0; tag_gnt_i = 1'b0; line_gnt_i = 1'b0; line_done_i = 1'b0;
      lock_cnt = 0; line_pend = 1'b0;
    end else begin
      if (lock_req_o) begin
        lock_gnt_i = (lock_cnt >= lock_delay);
        lock_cnt++;
      end else begin
        lock_gnt_i = 1'b0;
        lock_cnt = 0;
      end
      tag_gnt_i   = tag_req_o;
      line_done_i = line_pend;
      line_gnt_i  = line_req_o;
      line_pend   = line_req_o;
    end
  end

  // Scoreboard monitor: records accepts, line ops and tag writes; compares at ack.
  vec_t         exp_q[$];
  vec_t         mv;
  int           cyc = 0, acc_cyc = 0;
  bit           in_txn = 0, acc_flag = 0, seen_line = 0, seen_wr = 0, prev_ack = 0;
  cmo_line_op_t s_lop;
  logic [NW-1:0] s_lway, s_wway;
  logic [SW-1:0] s_lidx, s_widx;
  logic [TW-1:0] s_ltag;
  logic          s_wv, s_wd;

  always @(negedge clk) begin
    cyc++;
    if (!rst_ni) begin
      in_txn = 0; prev_ack = 0;
    end else begin
      if (prev_ack) chk("ack_one_cycle", cmo_resp_o.ack, 1'b0);
      prev_ack = cmo_resp_o.ack;
      if (in_txn) chk("busy_ready", cmo_resp_o.req_ready, 1'b0);
      if (cmo_req_i.req && cmo_resp_o.req_ready) begin
        acc_cyc = cyc; acc_flag = 1; in_txn = 1; seen_line = 0; seen_wr = 0;
      end
      if (line_req_o && !seen_line) begin
        seen_line = 1; s_lop = line_op_o; s_lway = line_way_o; s_lidx = line_idx_o;
        s_ltag = line_tag_o;
      end
      if (tag_req_o && tag_we_o && !seen_wr) begin
        seen_wr = 1; s_wway = tag_wway_o; s_widx = tag_idx_o; s_wv = tag_wvalid_o;
        s_wd = tag_wdirty_o;
      end
      if (cmo_resp_o.ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_expected", 1'b0, 1'b1);
        end else begin
          mv = exp_q.pop_front();
          chk("ack_latency", cyc - acc_cyc, mv.lat);
          chk("ack_trans_id", cmo_resp_o.trans_id, mv.tid);
          chk("lock_at_ack", lock_req_o, mv.lock);
          chk("line_op_seen", seen_line, mv.line);
          if (mv.line) begin
            chk("line_op", s_lop, mv.lop);
            chk("line_way", s_lway, mv.lway);
            chk("line_idx", s_lidx, idxof(mv.addr));
            chk("line_tag", s_ltag, tagof(mv.addr));
          end
          chk("tag_wr_seen", seen_wr, mv.wr);
          if (mv.wr) begin
            chk("tag_wway", s_wway, mv.wway);
            chk("tag_widx", s_widx, idxof(mv.addr));
            chk("tag_wvalid", s_wv, mv.wv);
            chk("tag_wdirty", s_wd, mv.wd);
          end
        end
        in_txn = 0;
      end
    end
  end

  task automatic setup_tags(input vec_t v);
    for (int w = 0; w < NW; w++) begin
      tag_rtag_i[w*TW +: TW] = v.hitm[w] ? tagof(v.addr) : ~tagof(v.addr);
    end
    tag_rvalid_i = v.vld;
    tag_rdirty_i = v.dty;
    lock_delay   = v.ldly;
  endtask

  task automatic start_req(input vec_t v);
    bit acc = 0;
    @(posedge clk); #2;
    setup_tags(v);
    acc_flag = 0;
    cmo_req_i.trans_id = v.tid; cmo_req_i.address = v.addr; cmo_req_i.cmo_op = v.op;
    cmo_req_i.req = 1'b1;
    exp_q.push_back(v);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #2;
      if (acc_flag) begin acc = 1; break; end
    end
    cmo_req_i.req = 1'b0;
    acc_flag = 0;
    chk("accepted", acc, 1'b1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("txn_complete", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, |{cmo_resp_o, lock_req_o, tag_req_o, tag_we_o, tag_idx_o, tag_wway_o,
                tag_wvalid_o, tag_wdirty_o, line_req_o, line_op_o, line_idx_o,
                line_way_o, line_tag_o}, 1'b0);
  endtask

  localparam logic [63:0] A = 64'h0000_0000_8000_1230;
  localparam logic [63:0] B = 64'hFF12_3456_789A_BCD0;

  vec_t vt[15];
  vec_t hv;
  int   nacc, c1, c2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          op              addr tid hitm   vld    dty    ld lat lk ln lop              lway   wr v  d  wway
    vt[0]  = mk(CMO_INVAL,      A, 4'd5,  4'h0, 4'hF, 4'hF, 0, 4, 1, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);
    vt[1]  = mk(CMO_FLUSH,      A, 4'd1,  4'h4, 4'hF, 4'h4, 0, 7, 1, 1, LINE_WB,         4'h4, 1, 0, 0, 4'h4);
    vt[2]  = mk(CMO_CLEAN,      A, 4'd2,  4'h9, 4'hF, 4'h8, 0, 4, 1, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);
    vt[3]  = mk(CMO_ZERO,       B, 4'd3,  4'h0, 4'h0, 4'h0, 0, 6, 1, 1, LINE_ZERO_MEM,   4'h0, 0, 0, 0, 4'h0);
    vt[4]  = mk(CMO_ZERO,       A, 4'd4,  4'h2, 4'hF, 4'h0, 0, 7, 1, 1, LINE_ZERO_LOCAL, 4'h2, 1, 1, 1, 4'h2);
    vt[5]  = mk(CMO_CLEAN,      B, 4'd6,  4'h8, 4'hF, 4'h8, 0, 7, 1, 1, LINE_WB,         4'h8, 1, 1, 0, 4'h8);
    vt[6]  = mk(CMO_FLUSH,      A, 4'd7,  4'h2, 4'hF, 4'h0, 0, 5, 1, 0, LINE_WB,         4'h0, 1, 0, 0, 4'h2);
    vt[7]  = mk(CMO_INVAL,      B, 4'd11, 4'h1, 4'hF, 4'h1, 0, 5, 1, 0, LINE_WB,         4'h0, 1, 0, 0, 4'h1);
    vt[8]  = mk(CMO_PREFETCH_R, A, 4'd8,  4'hF, 4'hF, 4'hF, 0, 1, 0, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);
    vt[9]  = mk(CMO_NONE,       A, 4'd9,  4'hF, 4'hF, 4'hF, 0, 1, 0, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);
    vt[10] = mk(CMO_INVAL,      A, 4'd12, 4'h4, 4'hB, 4'h0, 0, 4, 1, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);
    vt[11] = mk(CMO_FLUSH,      B, 4'd13, 4'h0, 4'hF, 4'hF, 0, 4, 1, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);
    vt[12] = mk(CMO_PREFETCH_W, B, 4'd14, 4'h1, 4'h1, 4'h1, 0, 1, 0, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);
    vt[13] = mk(CMO_PREFETCH_I, B, 4'd15, 4'h1, 4'h1, 4'h1, 0, 1, 0, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);
    vt[14] = mk(CMO_CLEAN,      A, 4'd0,  4'h0, 4'hF, 4'h0, 3, 7, 1, 0, LINE_WB,         4'h0, 0, 0, 0, 4'h0);

    // Reset: every output 0, req_ready rises one cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs_zero");
    @(posedge clk); #2;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle_after_release", cmo_resp_o.req_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_release", cmo_resp_o.req_ready, 1'b1);

    // Table-driven vectors.
    for (int i = 0; i < 15; i++) begin
      start_req(vt[i]);
      wait_done();
    end

    // Lock granted 10 cycles late while a second request is held high.
    hv = mk(CMO_CLEAN, A, 4'd10, 4'h0, 4'hF, 4'h0, 10, 14, 1, 0, LINE_WB, 4'h0, 0, 0, 0, 4'h0);
    @(posedge clk); #2;
    setup_tags(hv);
    acc_flag = 0; nacc = 0; c1 = 0; c2 = 0;
    cmo_req_i.trans_id = hv.tid; cmo_req_i.address = hv.addr; cmo_req_i.cmo_op = hv.op;
    cmo_req_i.req = 1'b1;
    exp_q.push_back(hv);
    exp_q.push_back(hv);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      if (acc_flag) begin
        acc_flag = 0; nacc++;
        if (nacc == 1) c1 = cyc;
        else c2 = cyc;
        if (nacc == 2) break;
      end
    end
    cmo_req_i.req = 1'b0;
    chk("held_req_accepts", nacc, 2);
    chk("reaccept_gap", c2 - c1, 15);
    wait_done();

    // Reset asserted while waiting for line_done: outputs clear on the next cycle.
    start_req(vt[1]);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (line_req_o) break;
    end
    chk("line_req_reached", line_req_o, 1'b1);
    @(posedge clk); #2;
    chk("in_line_wait_lock", lock_req_o, 1'b1);
    rst_ni = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("mid_op_reset_outputs_zero");
    chk("mid_op_reset_lock_dropped", lock_req_o, 1'b0);
    @(posedge clk); #2;
    rst_ni = 1'b1;

    // Recovery after abandoned operation.
    start_req(vt[0]);
    wait_done();
    start_req(vt[4]);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
